// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one word request at a time, waits a fixed number of
// cycles, performs a byte-masked store or a word load, then answers on a response channel.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic [31:0] r_mem [DEPTH];

  logic            w_direct;
  logic            w_do_access;
  logic            w_acc_we;
  logic [31:0]     w_acc_addr;
  logic [31:0]     w_acc_wdata;
  logic [3:0]      w_acc_be;
  logic            w_acc_err;
  logic [IDXW-1:0] w_idx;
  logic [31:0]     w_rdata;

  // With no wait states the access uses the request straight off the port on the accept edge.
  assign w_direct    = (WAIT_CYCLES == 0) && (r_state == S_IDLE) && req_valid;
  assign w_do_access = w_direct || ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_acc_we    = w_direct ? req_we    : r_we;
  assign w_acc_addr  = w_direct ? req_addr  : r_addr;
  assign w_acc_wdata = w_direct ? req_wdata : r_wdata;
  assign w_acc_be    = w_direct ? req_be    : r_be;
  assign w_acc_err   = (w_acc_addr[1:0] != 2'b00) || (w_acc_addr[31:2] >= 30'(DEPTH));
  assign w_idx       = w_acc_addr[IDXW+1:2];
  assign w_rdata     = (w_acc_err || w_acc_we) ? 32'd0 : r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (w_do_access && w_acc_we && !w_acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_be        <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we        <= req_we;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_be        <= req_be;
            r_req_ready <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              r_state     <= S_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= w_rdata;
              r_rsp_err   <= w_acc_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= 4'(WAIT_CYCLES);
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state     <= S_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= w_rdata;
            r_rsp_err   <= w_acc_err;
          end
        end
        S_RESP: begin
          // Response data is deliberately left in place after the handshake.
          if (rsp_ready) begin
            r_state     <= S_IDLE;
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states, one with none,
// sharing clock, reset and request payload but with separate valid lines.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req_valid, b_req_valid;
  logic        req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_ready;
  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_rsp_rdata;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the two-wait-state instance; lat counts edges from accept to rsp_valid.
  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] be, input logic holdRsp,
                               output logic [31:0] rdata, output logic err, output int lat);
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    req_be      = be;
    rsp_ready   = !holdRsp;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    lat = 0;
    while (!a_rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    checkOutput("rspTimeout", 32'(lat < 20), 32'd1);
    rdata = a_rsp_rdata;
    err   = a_rsp_err;
    if (!holdRsp) tick();
  endtask

  // One transaction on the zero-wait instance; each call is exactly two cycles long.
  task automatic applyStimulusB(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expData);
    checkOutput("bReqReady", b_req_ready, 1'b1);
    req_we      = we;
    req_addr    = addr;
    req_wdata   = wdata;
    req_be      = 4'hF;
    rsp_ready   = 1'b1;
    b_req_valid = 1'b1;
    tick();
    b_req_valid = 1'b0;
    checkOutput("bRspValid", b_rsp_valid, 1'b1);
    checkOutput("bRspData", b_rsp_rdata, expData);
    checkOutput("bRspErr", b_rsp_err, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    reset = 1'b0;
    a_req_valid = 1'b0; b_req_valid = 1'b0;
    req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0; rsp_ready = 1'b1;

    // Reset and idle
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checkOutput("rstReqReady", a_req_ready, 1'b1);
    checkOutput("rstRspValid", a_rsp_valid, 1'b0);
    checkOutput("rstRdata", a_rsp_rdata, 32'd0);
    checkOutput("rstErr", a_rsp_err, 1'b0);
    repeat (3) tick();
    checkOutput("idleReqReady", a_req_ready, 1'b1);
    checkOutput("idleRspValid", a_rsp_valid, 1'b0);
    checkOutput("idleBReqReady", b_req_ready, 1'b1);

    // Store then load with latency check
    applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat);
    checkOutput("storeLatency", 32'(lat + 1), 32'd3);
    checkOutput("storeErr", er, 1'b0);
    checkOutput("storeRdata", rd, 32'd0);
    checkOutput("postStoreReady", a_req_ready, 1'b1);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("loadLatency", 32'(lat + 1), 32'd3);
    checkOutput("loadData", rd, 32'hDEADBEEF);
    checkOutput("loadErr", er, 1'b0);

    // Byte enables
    applyStimulus(1'b1, 32'h10, 32'h11223344, 4'b0101, 1'b0, rd, er, lat);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("byteMerge", rd, 32'hDE22BE44);

    // Seed words used by the error and reset tests
    applyStimulus(1'b1, 32'h0, 32'h0BADF00D, 4'hF, 1'b0, rd, er, lat);
    applyStimulus(1'b1, 32'h20, 32'h12345678, 4'hF, 1'b0, rd, er, lat);

    // Errors: misaligned load, out-of-range store
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("preErrLoad", rd, 32'hDE22BE44);
    applyStimulus(1'b0, 32'h12, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("misalignErr", er, 1'b1);
    checkOutput("misalignRdata", rd, 32'd0);
    applyStimulus(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, lat);
    checkOutput("rangeErr", er, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("word0Kept", rd, 32'h0BADF00D);
    checkOutput("word0Err", er, 1'b0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("word4Kept", rd, 32'hDE22BE44);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("word8Kept", rd, 32'h12345678);

    // Response backpressure with an ignored request pulse
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, rd, er, lat);
    checkOutput("bpFirstData", rd, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0; req_be = 4'hF;
        a_req_valid = 1'b1;
      end
      tick();
      a_req_valid = 1'b0;
      checkOutput("bpRspValid", a_rsp_valid, 1'b1);
      checkOutput("bpRdata", a_rsp_rdata, 32'h12345678);
      checkOutput("bpErr", a_rsp_err, 1'b0);
      checkOutput("bpReqReady", a_req_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    checkOutput("bpReleaseValid", a_rsp_valid, 1'b0);
    checkOutput("bpReleaseReady", a_req_ready, 1'b1);
    checkOutput("bpRdataKept", a_rsp_rdata, 32'h12345678);
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("bpPulseIgnored", rd, 32'h12345678);

    // Zero wait states: back-to-back transactions every two cycles
    applyStimulusB(1'b1, 32'h0, 32'hA5A5A5A5, 32'd0);
    applyStimulusB(1'b1, 32'h4, 32'h5A5A5A5A, 32'd0);
    applyStimulusB(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5);
    applyStimulusB(1'b0, 32'h4, 32'h0, 32'h5A5A5A5A);
    applyStimulusB(1'b0, 32'h0, 32'h0, 32'hA5A5A5A5);

    // Reset asserted while the store is in WAIT
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0000CAFE; req_be = 4'hF;
    rsp_ready = 1'b1;
    a_req_valid = 1'b1;
    tick();
    a_req_valid = 1'b0;
    checkOutput("waitReqReady", a_req_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkOutput("asyncRstReady", a_req_ready, 1'b1);
    checkOutput("asyncRstValid", a_rsp_valid, 1'b0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("noRspAfterRst", a_rsp_valid, 1'b0);
    end
    applyStimulus(1'b0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
    checkOutput("droppedStore", rd, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
